sd_cache_lock_manager: RTL and testbench

SD_CACHE_LOCK_MANAGER -- requirements
Module: sd_cache_lock_manager

---
 rtl/sd_lock_pkg.sv | 22 ++
 rtl/sd_lock_slot.sv | 76 +++++++
 rtl/sd_cache_lock_manager.sv | 139 +++++++++++++
 tb/tb_sd_cache_lock_manager.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_lock_pkg.sv
// Shared encodings for the cache-line lock manager: response status,
// request opcode and per-slot state.
package sd_lock_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_BUSY = 2'b01,
        ST_FULL = 2'b10,
        ST_ERR  = 2'b11
    } lock_status_e;

    typedef enum logic {
        OP_ACQUIRE = 1'b0,
        OP_RELEASE = 1'b1
    } lock_op_e;

    typedef enum logic {
        SLOT_FREE = 1'b0,
        SLOT_HELD = 1'b1
    } slot_state_e;

endpackage

// File: rtl/sd_lock_slot.sv
// One lock slot: holds tag, owner and a saturating lease counter, and reports
// whether the incoming request hits it and whether its lease ends this cycle.
module sd_lock_slot
    import sd_lock_pkg::*;
#(
    parameter int TAG_W   = 26,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_i,
    input  logic             refresh_i,
    input  logic             free_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic [ID_W-1:0]  req_id_i,
    output logic             held_o,
    output logic             hit_o,
    output logic             own_o,
    output logic             expire_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    slot_state_e      state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lease_end;

    assign held_o    = (state_q == SLOT_HELD);
    assign hit_o     = held_o && (tag_q == req_tag_i);
    assign own_o     = hit_o && (owner_q == req_id_i);
    assign lease_end = held_o && (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    // A refresh or release landing on the final lease cycle wins over expiry.
    assign expire_o  = lease_end && !refresh_i && !free_i;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (alloc_i) begin
            state_d = SLOT_HELD;
            tag_d   = req_tag_i;
            owner_d = req_id_i;
            cnt_d   = '0;
        end else if (free_i || expire_o) begin
            state_d = SLOT_FREE;
            tag_d   = '0;
            owner_d = '0;
            cnt_d   = '0;
        end else if (refresh_i) begin
            cnt_d = '0;
        end else if (held_o && (TIMEOUT > 0) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_FREE;
            tag_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_cache_lock_manager.sv
// Cache-line lock manager: NUM_SLOTS lease-based locks with a single
// outstanding registered response and lowest-index-free allocation.
module sd_cache_lock_manager
    import sd_lock_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TAG_W     = 26,
    parameter int ID_W      = 2,
    parameter int TIMEOUT   = 1024,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic [ID_W-1:0]      req_id,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_status,
    output logic [SLOT_W-1:0]    rsp_slot,
    output logic [NUM_SLOTS-1:0] lock_vec,
    output logic                 timeout_evt
);

    logic [NUM_SLOTS-1:0] held_vec, hit_vec, own_vec, expire_vec;
    logic [NUM_SLOTS-1:0] alloc_vec, refresh_vec, free_vec, free_oh;
    logic                 accept;
    logic [SLOT_W-1:0]    hit_idx, free_idx, dec_slot;
    lock_status_e         dec_status;

    logic                 rsp_valid_q, rsp_valid_d;
    lock_status_e         rsp_status_q, rsp_status_d;
    logic [SLOT_W-1:0]    rsp_slot_q, rsp_slot_d;
    logic                 timeout_evt_q, timeout_evt_d;

    assign req_ready = ~rsp_valid_q | rsp_ready;
    assign accept    = req_valid & req_ready;
    // Lowest clear bit of held_vec, one-hot.
    assign free_oh   = ~held_vec & (held_vec + 1'b1);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sd_lock_slot #(
            .TAG_W   (TAG_W),
            .ID_W    (ID_W),
            .TIMEOUT (TIMEOUT)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .alloc_i   (alloc_vec[g]),
            .refresh_i (refresh_vec[g]),
            .free_i    (free_vec[g]),
            .req_tag_i (req_tag),
            .req_id_i  (req_id),
            .held_o    (held_vec[g]),
            .hit_o     (hit_vec[g]),
            .own_o     (own_vec[g]),
            .expire_o  (expire_vec[g])
        );
    end

    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_vec[i]) hit_idx = SLOT_W'(i);
            if (free_oh[i]) free_idx = SLOT_W'(i);
        end
    end

    // Decision uses pre-expiry slot state; slot commands only fire on accept.
    always_comb begin
        dec_status  = ST_OK;
        dec_slot    = '0;
        alloc_vec   = '0;
        refresh_vec = '0;
        free_vec    = '0;
        if (req_op == OP_RELEASE) begin
            if (|own_vec) begin
                dec_slot = hit_idx;
                free_vec = own_vec;
            end else begin
                dec_status = ST_ERR;
            end
        end else if (|own_vec) begin
            dec_slot    = hit_idx;
            refresh_vec = own_vec;
        end else if (|hit_vec) begin
            dec_status = ST_BUSY;
            dec_slot   = hit_idx;
        end else if (|free_oh) begin
            dec_slot  = free_idx;
            alloc_vec = free_oh;
        end else begin
            dec_status = ST_FULL;
        end
        if (!accept) begin
            alloc_vec   = '0;
            refresh_vec = '0;
            free_vec    = '0;
        end
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_slot_d    = rsp_slot_q;
        timeout_evt_d = |expire_vec;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = dec_status;
            rsp_slot_d   = dec_slot;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_slot_q    <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_slot_q    <= rsp_slot_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_slot    = rsp_slot_q;
    assign lock_vec    = held_vec;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_sd_cache_lock_manager.sv
// Directed bench for the lock manager: a default-lease instance for the
// protocol cases and a TIMEOUT=8 instance for the lease-expiry cases.
module tb_sd_cache_lock_manager;
    import sd_lock_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqValid8, reqOp, rspReady;
    logic [25:0] reqTag;
    logic [1:0]  reqId;

    logic        reqReady, rspValid, timeoutEvt;
    logic [1:0]  rspStatus, rspSlot;
    logic [3:0]  lockVec;
    logic        reqReady8, rspValid8, timeoutEvt8;
    logic [1:0]  rspStatus8, rspSlot8;
    logic [3:0]  lockVec8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sd_cache_lock_manager #(.NUM_SLOTS(4), .TAG_W(26), .ID_W(2), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady),
        .req_op(reqOp), .req_tag(reqTag), .req_id(reqId), .rsp_valid(rspValid),
        .rsp_ready(rspReady), .rsp_status(rspStatus), .rsp_slot(rspSlot),
        .lock_vec(lockVec), .timeout_evt(timeoutEvt)
    );

    sd_cache_lock_manager #(.NUM_SLOTS(4), .TAG_W(26), .ID_W(2), .TIMEOUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid8), .req_ready(reqReady8),
        .req_op(reqOp), .req_tag(reqTag), .req_id(reqId), .rsp_valid(rspValid8),
        .rsp_ready(rspReady), .rsp_status(rspStatus8), .rsp_slot(rspSlot8),
        .lock_vec(lockVec8), .timeout_evt(timeoutEvt8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle, returning 1ns after the edge.
    task automatic applyStimulus(input logic toDut8, input logic op,
                                 input logic [25:0] tag, input logic [1:0] id);
        reqOp  = op;
        reqTag = tag;
        reqId  = id;
        if (toDut8) reqValid8 = 1'b1;
        else        reqValid  = 1'b1;
        @(posedge clk);
        #1;
        reqValid  = 1'b0;
        reqValid8 = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; reqValid = 1'b0; reqValid8 = 1'b0; rspReady = 1'b1;
        reqOp = 1'b0; reqTag = '0; reqId = '0;
        #12;
        checkOutput("rst_rsp_valid", rspValid, 0);
        checkOutput("rst_rsp_status", rspStatus, ST_OK);
        checkOutput("rst_rsp_slot", rspSlot, 0);
        checkOutput("rst_lock_vec", lockVec, 4'b0000);
        checkOutput("rst_timeout_evt", timeoutEvt, 0);
        checkOutput("rst_req_ready", reqReady, 1);
        checkOutput("rst_lock_vec8", lockVec8, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, OP_ACQUIRE, 26'h100, 2'd1);
        checkOutput("acq1_valid", rspValid, 1);
        checkOutput("acq1_status", rspStatus, ST_OK);
        checkOutput("acq1_slot", rspSlot, 0);
        checkOutput("acq1_lock", lockVec, 4'b0001);

        applyStimulus(0, OP_ACQUIRE, 26'h100, 2'd2);
        checkOutput("busy_status", rspStatus, ST_BUSY);
        checkOutput("busy_slot", rspSlot, 0);
        checkOutput("busy_lock", lockVec, 4'b0001);

        applyStimulus(0, OP_RELEASE, 26'h100, 2'd2);
        checkOutput("relerr_status", rspStatus, ST_ERR);
        checkOutput("relerr_slot", rspSlot, 0);
        checkOutput("relerr_lock", lockVec, 4'b0001);

        applyStimulus(0, OP_ACQUIRE, 26'h100, 2'd1);
        checkOutput("reentrant_status", rspStatus, ST_OK);
        checkOutput("reentrant_lock", lockVec, 4'b0001);

        applyStimulus(0, OP_ACQUIRE, 26'h200, 2'd1);
        checkOutput("fill1_slot", rspSlot, 1);
        applyStimulus(0, OP_ACQUIRE, 26'h300, 2'd2);
        checkOutput("fill2_slot", rspSlot, 2);
        applyStimulus(0, OP_ACQUIRE, 26'h400, 2'd3);
        checkOutput("fill3_slot", rspSlot, 3);
        checkOutput("fill3_lock", lockVec, 4'b1111);

        applyStimulus(0, OP_ACQUIRE, 26'h500, 2'd0);
        checkOutput("full_status", rspStatus, ST_FULL);
        checkOutput("full_slot", rspSlot, 0);
        checkOutput("full_lock", lockVec, 4'b1111);

        applyStimulus(0, OP_RELEASE, 26'h300, 2'd2);
        checkOutput("rel2_status", rspStatus, ST_OK);
        checkOutput("rel2_slot", rspSlot, 2);
        checkOutput("rel2_lock", lockVec, 4'b1011);

        applyStimulus(0, OP_ACQUIRE, 26'h500, 2'd0);
        checkOutput("retry_status", rspStatus, ST_OK);
        checkOutput("retry_slot", rspSlot, 2);
        checkOutput("retry_lock", lockVec, 4'b1111);

        applyStimulus(0, OP_RELEASE, 26'h999, 2'd0);
        checkOutput("relmiss_status", rspStatus, ST_ERR);
        checkOutput("relmiss_slot", rspSlot, 0);

        idleCycles(1);
        checkOutput("drain_valid", rspValid, 0);

        rspReady = 1'b0;
        applyStimulus(0, OP_RELEASE, 26'h400, 2'd3);
        checkOutput("bp_first_status", rspStatus, ST_OK);
        checkOutput("bp_first_slot", rspSlot, 3);
        checkOutput("bp_first_lock", lockVec, 4'b0111);
        reqOp = OP_ACQUIRE; reqTag = 26'h600; reqId = 2'd1; reqValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_req_ready", reqReady, 0);
            checkOutput("bp_rsp_valid", rspValid, 1);
            checkOutput("bp_rsp_slot", rspSlot, 3);
            checkOutput("bp_lock", lockVec, 4'b0111);
        end
        rspReady = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkOutput("bp_after_status", rspStatus, ST_OK);
        checkOutput("bp_after_slot", rspSlot, 3);
        checkOutput("bp_after_lock", lockVec, 4'b1111);

        applyStimulus(0, OP_RELEASE, 26'h600, 2'd1);
        rspReady = 1'b0;
        checkOutput("prerst_valid", rspValid, 1);
        checkOutput("prerst_lock", lockVec, 4'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_lock", lockVec, 4'b0000);
        checkOutput("midrst_valid", rspValid, 0);
        checkOutput("midrst_req_ready", reqReady, 1);
        @(negedge clk); rst_n = 1'b1; rspReady = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, OP_ACQUIRE, 26'h100, 2'd2);
        checkOutput("postrst_status", rspStatus, ST_OK);
        checkOutput("postrst_slot", rspSlot, 0);
        checkOutput("postrst_lock", lockVec, 4'b0001);

        applyStimulus(1, OP_ACQUIRE, 26'h10, 2'd1);
        checkOutput("t8_grant_status", rspStatus8, ST_OK);
        checkOutput("t8_grant_lock", lockVec8, 4'b0001);
        for (int k = 1; k < 8; k++) begin
            idleCycles(1);
            checkOutput("t8_hold_lock", lockVec8, 4'b0001);
            checkOutput("t8_hold_evt", timeoutEvt8, 0);
        end
        idleCycles(1);
        checkOutput("t8_expire_lock", lockVec8, 4'b0000);
        checkOutput("t8_expire_evt", timeoutEvt8, 1);
        idleCycles(1);
        checkOutput("t8_evt_single", timeoutEvt8, 0);

        applyStimulus(1, OP_ACQUIRE, 26'h20, 2'd1);
        idleCycles(7);
        applyStimulus(1, OP_ACQUIRE, 26'h20, 2'd1);
        checkOutput("t8_refresh_status", rspStatus8, ST_OK);
        checkOutput("t8_refresh_lock", lockVec8, 4'b0001);
        checkOutput("t8_refresh_evt", timeoutEvt8, 0);
        idleCycles(7);
        checkOutput("t8_refresh_hold", lockVec8, 4'b0001);
        idleCycles(1);
        checkOutput("t8_refresh_expire", lockVec8, 4'b0000);
        checkOutput("t8_refresh_expire_evt", timeoutEvt8, 1);

        applyStimulus(1, OP_ACQUIRE, 26'h30, 2'd2);
        idleCycles(7);
        applyStimulus(1, OP_RELEASE, 26'h30, 2'd2);
        checkOutput("t8_release_status", rspStatus8, ST_OK);
        checkOutput("t8_release_lock", lockVec8, 4'b0000);
        checkOutput("t8_release_evt", timeoutEvt8, 0);
        idleCycles(1);
        checkOutput("t8_release_evt_late", timeoutEvt8, 0);
        checkOutput("main_no_expiry", lockVec, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
